button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_COUNT, default 200, meaning tick_fast ticks of continuous hold before a long press is declared (1 s at 200 Hz); legal range >= 1.
REQ-002 Parameter REPEAT_COUNT, default 40, meaning tick_fast ticks between auto-repeat pulses after a long press (5 Hz at 200 Hz); legal range >= 1.
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tick_fast  input  1  one-clk-wide timing strobe, the same strobe that drives the button debouncer.
REQ-006 btn_deb  input  1  debounced, already-synchronous button level, 1 = pressed.
REQ-007 press_pulse  output  1  one-clk pulse on each new press.
REQ-008 short_pulse  output  1  one-clk pulse on release before the long-press threshold is reached.
REQ-009 long_pulse  output  1  one-clk pulse when the long-press threshold is reached.
REQ-010 repeat_pulse  output  1  one-clk pulse per auto-repeat interval while held after a long press.
REQ-011 held  output  1  level, 1 while FSM is not IDLE.

Function
REQ-012 All outputs are registered, and each pulse output is high for exactly one clk cycle per event.
REQ-013 The FSM has states IDLE, PRESSED and LONG, plus a tick counter cnt of width clog2(max(LONG_COUNT,REPEAT_COUNT)+1).
REQ-014 A rising edge is btn_deb=1 while the registered previous sample prev_btn=0; prev_btn updates every clk.
REQ-015 IDLE: on a rising edge -> PRESSED, cnt<=0, press_pulse asserted in the next clk cycle (latency 1 clk from the first high sample).
REQ-016 IDLE: btn_deb already high without an edge (e.g. held through reset release) produces no transition and no pulse.
REQ-017 PRESSED: btn_deb=0 -> IDLE, short_pulse asserted the next cycle, cnt<=0.
REQ-018 PRESSED: on tick_fast with btn_deb=1, if cnt==LONG_COUNT-1 -> LONG, cnt<=0, long_pulse next cycle; otherwise cnt<=cnt+1.
REQ-019 LONG: btn_deb=0 -> IDLE, cnt<=0, no short_pulse or other pulse.
REQ-020 LONG: on tick_fast with btn_deb=1, if cnt==REPEAT_COUNT-1 then repeat_pulse next cycle and cnt<=0 (wrap); otherwise cnt<=cnt+1.
REQ-021 When release and tick_fast occur in the same cycle, release wins and no long_pulse or repeat_pulse is generated.
REQ-022 cnt never exceeds max(LONG_COUNT,REPEAT_COUNT)-1, and no arithmetic overflow is possible.
REQ-023 LONG_COUNT=1 gives long_pulse on the first tick after press; REPEAT_COUNT=1 gives repeat_pulse on every tick in LONG.
REQ-024 held is 1 in PRESSED and LONG and 0 in IDLE, updating in the same cycle as the state register.
REQ-025 At most one of press_pulse, short_pulse, long_pulse and repeat_pulse is high in any cycle.

Reset
REQ-026 While rst=1: state=IDLE, cnt=0, prev_btn=0, and all outputs are 0, immediately and independent of clk.
REQ-027 Reset asserted mid-press aborts the press with no pulses emitted.
REQ-028 After reset release, a button already held must be released and re-pressed to generate press_pulse, since prev_btn is 0 but the IDLE entry rule requires an edge observed after release; implementation: prev_btn loads btn_deb on the first post-reset clk before edge detection is enabled.

Verification (LONG_COUNT=4, REPEAT_COUNT=2, tick_fast every 4th clk)
REQ-029 Press 6 clk then release -> press_pulse 1 clk after press, short_pulse 1 clk after release, no long_pulse, held high 6 cycles.
REQ-030 Hold 40 clk -> press_pulse, long_pulse after the 4th tick, repeat_pulse after ticks 6, 8 and 10, held high throughout, no short_pulse on release.
REQ-031 Release coincident with the 4th tick -> short_pulse only, no long_pulse, state IDLE.
REQ-032 rst pulsed at clk 20 of a held press -> all outputs 0 asynchronously; with btn still high after release of rst, no pulses until a release and re-press.
REQ-033 Two presses separated by a 1-clk release -> two press_pulse and two short_pulse, cnt restarting from 0 on each press.
REQ-034 Random btn_deb/tick stimulus -> assertions: one-hot pulses, pulse width 1, and held==(state!=IDLE).

Source files
------------

// File: rtl/button_event.sv
// Button event classifier: turns a debounced button level into press,
// short-release, long-press and auto-repeat pulses, timed by tick_fast.
module button_event #(
    parameter int LONG_COUNT   = 200,
    parameter int REPEAT_COUNT = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_fast,
    input  logic btn_deb,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int MAX_COUNT = (LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_COUNT - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          prev_btn;
    logic          armed;
    logic          rise;

    // Previous-sample register; edge detection is enabled only after the
    // first post-reset clock has loaded prev_btn with the live level, so a
    // button held through reset release is not mistaken for a new press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_btn <= 1'b0;
            armed    <= 1'b0;
        end else begin
            prev_btn <= btn_deb;
            armed    <= 1'b1;
        end
    end

    // Rising edge of the debounced level, gated until armed.
    always_comb begin
        rise = armed & btn_deb & ~prev_btn;
    end

    // Press classification FSM with registered pulse and level outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            press_pulse  <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            press_pulse  <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                    end else begin
                        held <= 1'b0;
                    end
                end

                PRESSED: begin
                    // Release takes priority over a coincident tick.
                    if (!btn_deb) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        short_pulse <= 1'b1;
                        held        <= 1'b0;
                    end else if (tick_fast) begin
                        if (cnt == LONG_LAST) begin
                            state      <= LONG;
                            cnt        <= '0;
                            long_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                LONG: begin
                    if (!btn_deb) begin
                        state <= IDLE;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end else if (tick_fast) begin
                        if (cnt == REPEAT_LAST) begin
                            cnt          <= '0;
                            repeat_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed and randomized bench for button_event with LONG_COUNT=4, REPEAT_COUNT=2.
module tb_button_event;

    logic clk;
    logic rst;
    logic tick_fast;
    logic btn_deb;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    int checks = 0;
    int errors = 0;

    button_event #(
        .LONG_COUNT  (4),
        .REPEAT_COUNT(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_fast   (tick_fast),
        .btn_deb     (btn_deb),
        .press_pulse (press_pulse),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .held        (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {press, short, long, repeat, held}
    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_HELD  = 5'b00001;
    localparam logic [4:0] O_PRESS = 5'b10001;
    localparam logic [4:0] O_SHORT = 5'b01000;
    localparam logic [4:0] O_LONG  = 5'b00101;
    localparam logic [4:0] O_REP   = 5'b00011;

    typedef struct {
        logic       btn;
        logic       tick;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] outs();
        return {press_pulse, short_pulse, long_pulse, repeat_pulse, held};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic b, input logic t);
        btn_deb   = b;
        tick_fast = t;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic b, input logic t, input logic [4:0] e);
        vec_t v;
        v.btn  = b;
        v.tick = t;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    // Invariant monitor: pulses one-hot and never wider than one cycle.
    logic [3:0] last_pulses = '0;
    always @(negedge clk) begin
        logic [3:0] p;
        p = {press_pulse, short_pulse, long_pulse, repeat_pulse};
        checks++;
        if (!$onehot0(p)) begin
            errors++;
            $display("FAIL onehot pulses got %b want at most one bit at %0t", p, $time);
        end
        checks++;
        if ((p & last_pulses) != 4'b0000) begin
            errors++;
            $display("FAIL pulse_width got %b after %b want no repeat at %0t", p, last_pulses, $time);
        end
        last_pulses <= p;
    end

    // Reference model state for the random phase
    int         m_state;
    int         m_cnt;
    logic       m_prev;
    logic       m_armed;

    function automatic logic [4:0] model_step(input logic b, input logic t);
        logic [4:0] e;
        logic       r;
        e = 5'b00000;
        r = m_armed && b && !m_prev;
        m_prev  = b;
        m_armed = 1'b1;
        if (m_state == 0) begin
            if (r) begin
                m_state = 1; m_cnt = 0; e[4] = 1'b1;
            end
        end else if (m_state == 1) begin
            if (!b) begin
                m_state = 0; m_cnt = 0; e[3] = 1'b1;
            end else if (t) begin
                if (m_cnt == 3) begin m_state = 2; m_cnt = 0; e[2] = 1'b1; end
                else m_cnt = m_cnt + 1;
            end
        end else begin
            if (!b) begin
                m_state = 0; m_cnt = 0;
            end else if (t) begin
                if (m_cnt == 1) begin m_cnt = 0; e[1] = 1'b1; end
                else m_cnt = m_cnt + 1;
            end
        end
        e[0] = (m_state != 0);
        return e;
    endfunction

    initial begin
        logic b;
        logic t;
        logic [4:0] e;

        // Press 6 clk then release
        add(0, 0, O_NONE);
        add(1, 0, O_PRESS);
        add(1, 0, O_HELD);
        add(1, 1, O_HELD);
        add(1, 0, O_HELD);
        add(1, 0, O_HELD);
        add(1, 0, O_HELD);
        add(0, 0, O_SHORT);
        add(0, 0, O_NONE);
        // Long press with back-to-back ticks, then release during a tick
        add(1, 0, O_PRESS);
        add(1, 1, O_HELD);
        add(1, 1, O_HELD);
        add(1, 1, O_HELD);
        add(1, 1, O_LONG);
        add(1, 1, O_HELD);
        add(1, 1, O_REP);
        add(1, 0, O_HELD);
        add(1, 1, O_HELD);
        add(1, 1, O_REP);
        add(0, 1, O_NONE);
        add(0, 0, O_NONE);
        // Release coincident with the 4th tick
        add(1, 0, O_PRESS);
        add(1, 1, O_HELD);
        add(1, 1, O_HELD);
        add(1, 1, O_HELD);
        add(0, 1, O_SHORT);
        add(0, 0, O_NONE);
        // Two presses separated by a 1-clk release
        add(1, 1, O_PRESS);
        add(1, 1, O_HELD);
        add(0, 0, O_SHORT);
        add(1, 0, O_PRESS);
        add(1, 1, O_HELD);
        add(1, 1, O_HELD);
        add(1, 1, O_HELD);
        add(0, 0, O_SHORT);
        add(0, 0, O_NONE);

        // Reset state
        rst = 1'b1; btn_deb = 1'b0; tick_fast = 1'b0;
        #1;
        chk("reset_async", outs(), O_NONE);
        @(posedge clk); @(posedge clk); #1;
        chk("reset_clocked", outs(), O_NONE);
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].btn, vecs[i].tick);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // 40-clk hold with tick every 4th clk
        for (int i = 0; i < 40; i++) begin
            apply(1'b1, (i % 4) == 3);
            if (i == 0) e = O_PRESS;
            else if (i == 15) e = O_LONG;
            else if (i == 23 || i == 31 || i == 39) e = O_REP;
            else e = O_HELD;
            chk($sformatf("hold40_c%0d", i), outs(), e);
        end
        apply(1'b0, 1'b0);
        chk("hold40_release", outs(), O_NONE);

        // Reset asserted mid-press, button still held after reset release
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, (i % 4) == 3);
        end
        chk("midpress_held", outs() & O_HELD, O_HELD);
        #3;
        rst = 1'b1;
        #1;
        chk("midpress_rst_async", outs(), O_NONE);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, (i % 2) == 1);
            chk($sformatf("post_rst_held%0d", i), outs(), O_NONE);
        end
        apply(1'b0, 1'b0);
        chk("post_rst_release", outs(), O_NONE);
        apply(1'b1, 1'b0);
        chk("post_rst_repress", outs(), O_PRESS);
        apply(1'b0, 1'b0);
        chk("post_rst_short", outs(), O_SHORT);

        // Random stimulus against the reference model
        rst = 1'b1;
        #1;
        chk("rand_reset", outs(), O_NONE);
        @(posedge clk); #1;
        rst = 1'b0;
        m_state = 0; m_cnt = 0; m_prev = 1'b0; m_armed = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) b = ~b;
            t = ($urandom_range(0, 2) == 0);
            e = model_step(b, t);
            apply(b, t);
            chk($sformatf("rand%0d", i), outs(), e);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
